// File: rtl/signal_debounce_if.sv
// Signal bundle between the raw serial line, the debouncer and the sequence detector.
// The glitch_cnt member exists only when DEBOUNCE_GLITCH_CNT_EN is defined.
interface signal_debounce_if;
  logic       signal_in;
  logic       signal_out;
  logic       rise_pulse;
  logic       fall_pulse;
  logic       busy;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif

  modport master (
    output signal_in,
    input  signal_out,
    input  rise_pulse,
    input  fall_pulse,
    input  busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
    , input glitch_cnt
`endif
  );

  modport slave (
    input  signal_in,
    output signal_out,
    output rise_pulse,
    output fall_pulse,
    output busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
    , output glitch_cnt
`endif
  );
endinterface

// File: rtl/signal_debounce.sv
// Synchroniser plus 4-state debouncer that qualifies a level after STABLE_CYCLES steady samples.
// Optional saturating rejected-glitch counter enabled by the DEBOUNCE_GLITCH_CNT_EN macro.
module signal_debounce #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic              clk,
  input  logic              rst,
  signal_debounce_if.slave  bus
);

  localparam logic [1:0] IDLE_LOW   = 2'd0;
  localparam logic [1:0] CHECK_HIGH = 2'd1;
  localparam logic [1:0] IDLE_HIGH  = 2'd2;
  localparam logic [1:0] CHECK_LOW  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [1:0]             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_out;
  logic                   r_rise;
  logic                   r_fall;
  logic                   r_busy;

  logic                   w_s;
  logic [1:0]             w_state_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_abort;

  assign w_s = r_sync[SYNC_STAGES-1];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) r_sync <= '0;
    else      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.signal_in};
  end

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rise      = 1'b0;
    w_fall      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      IDLE_LOW: begin
        if (w_s) begin
          w_state_nxt = CHECK_HIGH;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      CHECK_HIGH: begin
        if (!w_s) begin
          w_state_nxt = IDLE_LOW;
          w_cnt_nxt   = '0;
          w_abort     = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE_HIGH;
          w_cnt_nxt   = '0;
          w_rise      = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!w_s) begin
          w_state_nxt = CHECK_LOW;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      CHECK_LOW: begin
        if (w_s) begin
          w_state_nxt = IDLE_HIGH;
          w_cnt_nxt   = '0;
          w_abort     = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE_LOW;
          w_cnt_nxt   = '0;
          w_fall      = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE_LOW;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE_LOW;
      r_cnt   <= '0;
      r_out   <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rise  <= w_rise;
      r_fall  <= w_fall;
      r_busy  <= (w_state_nxt == CHECK_HIGH) || (w_state_nxt == CHECK_LOW);
      if (w_rise)      r_out <= 1'b1;
      else if (w_fall) r_out <= 1'b0;
    end
  end

  assign bus.signal_out = r_out;
  assign bus.rise_pulse = r_rise;
  assign bus.fall_pulse = r_fall;
  assign bus.busy       = r_busy;

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] r_glitch_cnt;

  // Saturates instead of wrapping so a noisy line never looks quiet again.
  always_ff @(posedge clk) begin
    if (!rst)                                r_glitch_cnt <= 8'd0;
    else if (w_abort && r_glitch_cnt != 8'hFF) r_glitch_cnt <= r_glitch_cnt + 8'd1;
  end

  assign bus.glitch_cnt = r_glitch_cnt;
`else
  logic w_abort_unused;
  assign w_abort_unused = w_abort;
`endif

endmodule

// File: tb/tb_signal_debounce.sv
// Self-checking bench for signal_debounce: directed scenarios plus randomized levels and spikes,
// compared every cycle against a sliding-window reference model.
`timescale 1ns/1ps
module tb_signal_debounce;

  localparam int SYNC  = 2;
  localparam int ST    = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  bit   chk_en;
  int   n_rise_seen;

  signal_debounce_if bus ();

  signal_debounce #(
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(ST),
    .CNT_W        (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: s is the raw input seen SYNC edges late; the accepted level flips once
  // the last ST samples of s all disagree with it. A run that ends early is one glitch.
  logic pipe [SYNC];
  logic win  [ST];
  logic m_out, m_rise, m_fall, m_busy;
  int   m_glitch;

  always @(posedge clk) begin
    logic s;
    logic prev;
    bit   all_new;
    if (!rst) begin
      for (int i = 0; i < SYNC; i++) pipe[i] = 1'b0;
      for (int i = 0; i < ST; i++)   win[i]  = 1'b0;
      m_out = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_busy = 1'b0; m_glitch = 0;
    end else begin
      s = pipe[SYNC-1];
      for (int i = SYNC-1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = bus.signal_in;
      prev = win[ST-1];
      for (int i = 0; i < ST-1; i++) win[i] = win[i+1];
      win[ST-1] = s;
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (s == m_out && prev != m_out && m_glitch < 255) m_glitch++;
      all_new = 1'b1;
      for (int i = 0; i < ST; i++) if (win[i] == m_out) all_new = 1'b0;
      if (all_new) begin
        m_rise = ~m_out;
        m_fall = m_out;
        m_out  = ~m_out;
      end
      m_busy = (s != m_out);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cycle_outs", {28'd0, bus.signal_out, bus.rise_pulse, bus.fall_pulse, bus.busy},
            {28'd0, m_out, m_rise, m_fall, m_busy});
`ifdef DEBOUNCE_GLITCH_CNT_EN
      check("cycle_glitch_cnt", {24'd0, bus.glitch_cnt}, m_glitch);
`endif
      if (bus.rise_pulse) n_rise_seen++;
    end
  end

  task automatic settle(input logic lvl, input int n);
    @(negedge clk);
    bus.signal_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic spike(input int w);
    @(negedge clk);
    #2 bus.signal_in = ~bus.signal_in;
    #(w) bus.signal_in = ~bus.signal_in;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, busy_n, rise_n, r0, k;
    logic lvl;
    int len;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] g0;
`endif
    n_cmp = 0; n_err = 0; n_rise_seen = 0;
    rst = 1'b0;
    bus.signal_in = 1'b0;
    chk_en = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_signal_out", bus.signal_out, 0);
    check("rst_rise", bus.rise_pulse, 0);
    check("rst_fall", bus.fall_pulse, 0);
    check("rst_busy", bus.busy, 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    check("rst_glitch", bus.glitch_cnt, 0);
`endif
    @(negedge clk) rst = 1'b1;
    settle(1'b0, 5);

    // Clean rise: latency in edges, busy duration and single strobe
    @(negedge clk) bus.signal_in = 1'b1;
    lat = 0; busy_n = 0; rise_n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus.busy && lat == 0) busy_n++;
      if (bus.rise_pulse) rise_n++;
      if (bus.signal_out && lat == 0) lat = i;
    end
    check("rise_latency_edges", lat, SYNC + ST);
    check("rise_busy_cycles", busy_n, ST - 1);
    check("rise_pulse_count", rise_n, 1);
    settle(1'b0, 12);
    check("fall_level", bus.signal_out, 0);

    // Two-period glitch is rejected
`ifdef DEBOUNCE_GLITCH_CNT_EN
    g0 = bus.glitch_cnt;
`endif
    @(negedge clk) bus.signal_in = 1'b1;
    repeat (2) @(negedge clk);
    bus.signal_in = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_level_kept", bus.signal_out, 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    check("glitch_count_delta", bus.glitch_cnt - g0, 1);
`endif

    // Sub-period spikes never reach the synchroniser output
    spike(3); spike(5); spike(3);
    repeat (10) @(negedge clk);
    check("spike_level_kept", bus.signal_out, 0);

    // Alternating 25 ns levels, then stable high: exactly one rise
    r0 = n_rise_seen;
    @(posedge clk); #3;
    for (int i = 0; i < 8; i++) begin
      bus.signal_in = ~bus.signal_in;
      #25;
    end
    bus.signal_in = 1'b1;
    repeat (15) @(negedge clk);
    check("alt_single_rise", n_rise_seen - r0, 1);
    check("alt_final_level", bus.signal_out, 1);

    // Reset during CHECK_HIGH discards the candidate
    settle(1'b0, 12);
    @(negedge clk) bus.signal_in = 1'b1;
    k = 0;
    while (!bus.busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("busy_before_reset", bus.busy, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid_reset_outs", {bus.signal_out, bus.rise_pulse, bus.fall_pulse, bus.busy}, 0);
    @(negedge clk) rst = 1'b1;
    repeat (12) @(negedge clk);
    check("high_through_release", bus.signal_out, 1);

    // Saturating glitch counter
    settle(1'b0, 12);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk) bus.signal_in = 1'b1;
      repeat (2) @(negedge clk);
      bus.signal_in = 1'b0;
      repeat (3) @(negedge clk);
    end
    check("storm_level_kept", bus.signal_out, 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    check("glitch_saturated", bus.glitch_cnt, 255);
`endif

    // Randomized levels with occasional sub-period spikes
    for (int i = 0; i < 400; i++) begin
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 7);
      @(negedge clk) bus.signal_in = lvl;
      if ($urandom_range(0, 3) == 0) begin
        #2 bus.signal_in = ~lvl;
        #($urandom_range(1, 6)) bus.signal_in = lvl;
      end
      repeat (len - 1) @(negedge clk);
    end
    settle(1'b0, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
